// File: rtl/ysyx_24080006_mdu_seq_pkg.sv
// Shared types for the multiply/divide sequencer and its borrowed-ALU interface.
// Also holds iteration counts and the operand-extension helper.
package ysyx_24080006_mdu_seq_pkg;

    typedef enum logic [1:0] {
        MDU_MUL  = 2'b00,
        MDU_MULH = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_REM  = 2'b11
    } mdu_op_e;

    typedef struct packed {
        logic    mdu_enable;
        logic    signed_a;
        logic    signed_b;
        mdu_op_e mdu_op;
    } mdu_set_t;

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
    } mdu2alu_t;

    typedef struct packed {
        logic [33:0] res_34;
        logic [31:0] res_32;
        logic        not_zero;
    } alu2mdu_t;

    typedef enum logic [2:0] {
        IDLE,
        NEGB,
        ABSA,
        ABSB,
        CALC,
        FIX,
        DONE
    } mdu_state_e;

    localparam int MDU_MUL_ITER = 33;
    localparam int MDU_DIV_ITER = 32;
    localparam int MDU_CNT_W    = 6;

    function automatic logic [32:0] ext33(input logic [31:0] x, input logic s);
        return {s & x[31], x};
    endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_seq.sv
// MUL/MULH (34 ALU cycles) and DIV/REM (36 ALU cycles) sequencer on the borrowed EXU adder; result held while !out_ready.
// MDU_REUSE_EN adds a last-result cache so repeated operand sets complete the cycle after accept.
module ysyx_24080006_mdu_seq
    import ysyx_24080006_mdu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  mdu_set_t        mdu_set,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            alu_req,
    output mdu2alu_t        mdu2alu,
    input  alu2mdu_t        alu2mdu,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    mdu_state_e           r_state;
    mdu_state_e           w_next;
    logic [MDU_CNT_W-1:0] r_cnt;
    mdu_op_e              r_op;
    logic                 r_sa;
    logic                 r_sb;
    logic [31:0]          r_rs1;
    logic [31:0]          r_rs2;
    logic [32:0]          r_acc;   // product high half, or partial remainder
    logic [32:0]          r_lo;    // multiplier / product low half, or |A| shifting into quotient
    logic [32:0]          r_negb;
    logic [31:0]          r_result;

    logic                 w_is_mul;
    logic                 w_in_mul;
    logic                 w_accept;
    logic                 w_div0;
    logic                 w_hit;
    logic [31:0]          w_hit_val;
    logic [32:0]          w_a33;
    logic [32:0]          w_b33;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic                 w_fix_neg;
    logic [31:0]          w_fix_src;
    logic [63:0]          w_prod;
    logic                 w_q_bit;
    logic                 w_unused_nz;

    assign w_is_mul    = (r_op == MDU_MUL) || (r_op == MDU_MULH);
    assign w_in_mul    = (mdu_set.mdu_op == MDU_MUL) || (mdu_set.mdu_op == MDU_MULH);
    assign w_accept    = (r_state == IDLE) && in_valid && mdu_set.mdu_enable && !flush;
    assign w_div0      = !w_in_mul && (rs2 == '0);
    assign w_a33       = ext33(r_rs1, r_sa);
    assign w_b33       = ext33(r_rs2, r_sb);
    assign w_sign_a    = w_a33[32];
    assign w_sign_b    = w_b33[32];
    assign w_fix_neg   = (r_op == MDU_DIV) ? (w_sign_a ^ w_sign_b) : w_sign_a;
    assign w_fix_src   = (r_op == MDU_DIV) ? r_lo[31:0] : r_acc[31:0];
    // Product as it will stand after this final shift.
    assign w_prod      = {alu2mdu.res_34[31:0], r_lo[32:1]};
    assign w_q_bit     = !alu2mdu.res_34[33];
    assign w_unused_nz = alu2mdu.not_zero;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign result    = r_result;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        alu_req = 1'b0;
        mdu2alu = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_div0 || w_hit) begin
                        w_next = DONE;
                    end else if (w_in_mul) begin
                        w_next = NEGB;
                    end else begin
                        w_next = ABSA;
                    end
                end
            end
            ABSA: begin
                alu_req   = 1'b1;
                mdu2alu.a = w_sign_a ? ~w_a33 : w_a33;
                mdu2alu.b = {32'd0, w_sign_a};
                w_next    = ABSB;
            end
            ABSB: begin
                alu_req   = 1'b1;
                mdu2alu.a = w_sign_b ? ~w_b33 : w_b33;
                mdu2alu.b = {32'd0, w_sign_b};
                w_next    = NEGB;
            end
            NEGB: begin
                alu_req   = 1'b1;
                mdu2alu.a = w_is_mul ? ~w_b33 : ~r_negb;
                mdu2alu.b = 33'd1;
                w_next    = CALC;
            end
            CALC: begin
                alu_req = 1'b1;
                if (w_is_mul) begin
                    // The last step weighs multiplier bit 32 negatively.
                    mdu2alu.a = r_acc;
                    mdu2alu.b = r_lo[0] ? ((r_cnt == '0) ? r_negb : w_b33) : 33'd0;
                end else begin
                    mdu2alu.a = {r_acc[31:0], r_lo[31]};
                    mdu2alu.b = r_negb;
                end
                if (r_cnt == '0) begin
                    w_next = w_is_mul ? DONE : FIX;
                end
            end
            FIX: begin
                alu_req   = 1'b1;
                mdu2alu.a = w_fix_neg ? ~{1'b0, w_fix_src} : {1'b0, w_fix_src};
                mdu2alu.b = {32'd0, w_fix_neg};
                w_next    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (flush) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_op     <= MDU_MUL;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_negb   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op  <= mdu_set.mdu_op;
                        r_sa  <= mdu_set.signed_a;
                        r_sb  <= mdu_set.signed_b;
                        r_rs1 <= rs1;
                        r_rs2 <= rs2;
                        r_acc <= '0;
                        r_lo  <= ext33(rs1, mdu_set.signed_a);
                        if (w_div0) begin
                            r_result <= (mdu_set.mdu_op == MDU_DIV) ? 32'hFFFF_FFFF : rs1;
                        end else if (w_hit) begin
                            r_result <= w_hit_val;
                        end
                    end
                end
                ABSA: r_lo   <= alu2mdu.res_34[32:0];
                ABSB: r_negb <= alu2mdu.res_34[32:0];
                NEGB: begin
                    r_negb <= alu2mdu.res_34[32:0];
                    r_cnt  <= w_is_mul ? MDU_CNT_W'(MDU_MUL_ITER - 1) : MDU_CNT_W'(MDU_DIV_ITER - 1);
                end
                CALC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    if (w_is_mul) begin
                        r_acc <= alu2mdu.res_34[33:1];
                        r_lo  <= {alu2mdu.res_34[0], r_lo[32:1]};
                        if (r_cnt == '0) begin
                            r_result <= (r_op == MDU_MUL) ? w_prod[31:0] : w_prod[63:32];
                        end
                    end else begin
                        r_acc <= {1'b0, w_q_bit ? alu2mdu.res_34[31:0] : {r_acc[30:0], r_lo[31]}};
                        r_lo  <= {1'b0, r_lo[30:0], w_q_bit};
                    end
                end
                FIX: r_result <= alu2mdu.res_32;
                default: ;
            endcase
        end
    end

`ifdef MDU_REUSE_EN
    logic        r_c_vld;
    logic        r_c_mul;
    logic        r_c_sa;
    logic        r_c_sb;
    logic        r_c_q_ok;
    logic        r_c_r_ok;
    logic [31:0] r_c_rs1;
    logic [31:0] r_c_rs2;
    logic [63:0] r_c_val;   // product, or {quotient, remainder}
    logic        w_key_eq;

    // FIX only negates the value that was asked for; the other one is kept only when it needs no sign fix.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_c_vld <= 1'b0;
        end else if (flush) begin
            r_c_vld <= 1'b0;
        end else if ((r_state == CALC) && (r_cnt == '0) && w_is_mul) begin
            r_c_vld  <= 1'b1;
            r_c_mul  <= 1'b1;
            r_c_sa   <= r_sa;
            r_c_sb   <= r_sb;
            r_c_rs1  <= r_rs1;
            r_c_rs2  <= r_rs2;
            r_c_q_ok <= 1'b1;
            r_c_r_ok <= 1'b1;
            r_c_val  <= w_prod;
        end else if (r_state == FIX) begin
            r_c_vld <= 1'b1;
            r_c_mul <= 1'b0;
            r_c_sa  <= r_sa;
            r_c_sb  <= r_sb;
            r_c_rs1 <= r_rs1;
            r_c_rs2 <= r_rs2;
            if (r_op == MDU_DIV) begin
                r_c_val  <= {alu2mdu.res_32, r_acc[31:0]};
                r_c_q_ok <= 1'b1;
                r_c_r_ok <= !w_sign_a;
            end else begin
                r_c_val  <= {r_lo[31:0], alu2mdu.res_32};
                r_c_q_ok <= (w_sign_a == w_sign_b);
                r_c_r_ok <= 1'b1;
            end
        end
    end

    assign w_key_eq = r_c_vld && (r_c_sa == mdu_set.signed_a) && (r_c_sb == mdu_set.signed_b)
                      && (r_c_rs1 == rs1) && (r_c_rs2 == rs2);

    always_comb begin
        w_hit     = 1'b0;
        w_hit_val = '0;
        case (mdu_set.mdu_op)
            MDU_MUL: begin
                w_hit     = w_key_eq && r_c_mul;
                w_hit_val = r_c_val[31:0];
            end
            MDU_MULH: begin
                w_hit     = w_key_eq && r_c_mul;
                w_hit_val = r_c_val[63:32];
            end
            MDU_DIV: begin
                w_hit     = w_key_eq && !r_c_mul && r_c_q_ok;
                w_hit_val = r_c_val[63:32];
            end
            MDU_REM: begin
                w_hit     = w_key_eq && !r_c_mul && r_c_r_ok;
                w_hit_val = r_c_val[31:0];
            end
            default: ;
        endcase
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_val = '0;
`endif

endmodule

// File: tb/tb_ysyx_24080006_mdu_seq.sv
// Directed bench for the MDU sequencer with a behavioural 33-bit adder standing in for the EXU ALU.
module tb_ysyx_24080006_mdu_seq;
    import ysyx_24080006_mdu_seq_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    mdu_set_t    mdu_set;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        alu_req;
    mdu2alu_t    mdu2alu;
    alu2mdu_t    alu2mdu;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_24080006_mdu_seq #(.XLEN(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mdu_set   (mdu_set),
        .rs1       (rs1),
        .rs2       (rs2),
        .alu_req   (alu_req),
        .mdu2alu   (mdu2alu),
        .alu2mdu   (alu2mdu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always_comb begin
        alu2mdu.res_34   = {mdu2alu.a[32], mdu2alu.a} + {mdu2alu.b[32], mdu2alu.b};
        alu2mdu.res_32   = alu2mdu.res_34[31:0];
        alu2mdu.not_zero = |alu2mdu.res_34;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input mdu_op_e op, input logic sa, input logic sb,
                             input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        in_valid           = 1'b1;
        mdu_set.mdu_enable = 1'b1;
        mdu_set.signed_a   = sa;
        mdu_set.signed_b   = sb;
        mdu_set.mdu_op     = op;
        rs1                = a;
        rs2                = b;
        @(posedge clock);
    endtask

    // Ends on the negedge where out_valid is seen, leaving the result un-acknowledged.
    task automatic run_op(input mdu_op_e op, input logic sa, input logic sb,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int nalu);
        drive_req(op, sa, sb, a, b);
        lat  = 0;
        nalu = 0;
        do begin
            @(negedge clock);
            in_valid = 1'b0;
            lat++;
            if (alu_req) nalu++;
        end while (!out_valid && lat < 200);
        res = result;
        if (!out_valid) lat = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic op_check(input string tag, input mdu_op_e op, input logic sa, input logic sb,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] r;
        int          l;
        int          n;
        run_op(op, sa, sb, a, b, r, l, n);
        check(tag, {32'd0, r}, {32'd0, exp});
        release_out();
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        int          nalu;
        int          seen;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mdu_set   = '0;
        rs1       = '0;
        rs2       = '0;
        repeat (2) @(negedge clock);
        check("reset_ctrl {in_ready,out_valid,alu_req,busy}", {60'd0, in_ready, out_valid, alu_req, busy}, 64'h8);
        check("reset_result", {32'd0, result}, 64'd0);
        check("reset_mdu2alu", {30'd0, mdu2alu}, 64'd0);
        reset_n = 1'b1;

        run_op(MDU_MUL, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD, r, lat, nalu);
        check("mull_s_result", {32'd0, r}, 64'hFFFF_FFEB);
        check("mull_s_latency", 64'(lat), 64'd35);
        check("mull_s_alu_cycles", 64'(nalu), 64'd34);
        check("mull_done_in_ready", {63'd0, in_ready}, 64'd0);
        release_out();
        check("mull_release_idle", {62'd0, in_ready, busy}, 64'h2);

        op_check("mulh_uu", MDU_MULH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        op_check("mulh_su", MDU_MULH, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op_check("mulh_ss_min", MDU_MULH, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

        run_op(MDU_DIV, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, r, lat, nalu);
        check("div_s_result", {32'd0, r}, 64'hFFFF_FFFD);
        check("div_s_latency", 64'(lat), 64'd37);
        check("div_s_alu_cycles", 64'(nalu), 64'd36);
        release_out();
        op_check("rem_s_neg_dividend", MDU_REM, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        op_check("div_s_overflow", MDU_DIV, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        op_check("rem_s_overflow", MDU_REM, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        op_check("rem_s_neg_divisor", MDU_REM, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1);
        op_check("divu_big_divisor", MDU_DIV, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1);
        op_check("remu_big_divisor", MDU_REM, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);

        run_op(MDU_DIV, 1'b1, 1'b1, 32'h1234, 32'd0, r, lat, nalu);
        check("div0_result", {32'd0, r}, 64'hFFFF_FFFF);
        check("div0_latency", 64'(lat), 64'd1);
        check("div0_alu_cycles", 64'(nalu), 64'd0);
        release_out();
        run_op(MDU_REM, 1'b1, 1'b1, 32'h1234, 32'd0, r, lat, nalu);
        check("rem0_result", {32'd0, r}, 64'h1234);
        check("rem0_latency", 64'(lat), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("hold {result,out_valid,in_ready}", {30'd0, result, out_valid, in_ready}, {30'd0, 32'h1234, 2'b10});
        end
        release_out();

        // Flush during CALC iteration 10 of a multiply.
        drive_req(MDU_MUL, 1'b1, 1'b1, 32'h1111_1111, 32'h3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        check("pre_flush {busy,alu_req}", {62'd0, busy, alu_req}, 64'h3);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_calc {in_ready,busy,alu_req,out_valid}", {60'd0, in_ready, busy, alu_req, out_valid}, 64'h8);
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("flush_no_out_valid", 64'(seen), 64'd0);
        op_check("after_flush_mull", MDU_MUL, 1'b1, 1'b1, 32'h1234_5678, 32'h10, 32'h2345_6780);

        // Flush and request together in IDLE: the request is dropped.
        @(negedge clock);
        in_valid           = 1'b1;
        flush              = 1'b1;
        mdu_set.mdu_enable = 1'b1;
        mdu_set.mdu_op     = MDU_MUL;
        @(negedge clock);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_wins {in_ready,busy,alu_req}", {61'd0, in_ready, busy, alu_req}, 64'h4);

        // Flush while a result is waiting.
        run_op(MDU_DIV, 1'b0, 1'b0, 32'd5, 32'd0, r, lat, nalu);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_done {out_valid,in_ready}", {62'd0, out_valid, in_ready}, 64'h1);

        // Reset in the middle of a divide.
        drive_req(MDU_DIV, 1'b1, 1'b1, 32'd1000, 32'd3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_ctrl {in_ready,out_valid,alu_req,busy}", {60'd0, in_ready, out_valid, alu_req, busy}, 64'h8);
        check("midrst_result", {32'd0, result}, 64'd0);
        check("midrst_mdu2alu", {30'd0, mdu2alu}, 64'd0);
        reset_n = 1'b1;

        run_op(MDU_DIV, 1'b1, 1'b1, 32'd100, 32'd7, r, lat, nalu);
        check("reuse_div_result", {32'd0, r}, 64'd14);
        check("reuse_div_latency", 64'(lat), 64'd37);
        release_out();
        run_op(MDU_REM, 1'b1, 1'b1, 32'd100, 32'd7, r, lat, nalu);
        check("reuse_rem_result", {32'd0, r}, 64'd2);
`ifdef MDU_REUSE_EN
        check("reuse_rem_latency", 64'(lat), 64'd1);
        check("reuse_rem_alu_cycles", 64'(nalu), 64'd0);
`else
        check("reuse_rem_latency", 64'(lat), 64'd37);
        check("reuse_rem_alu_cycles", 64'(nalu), 64'd36);
`endif
        release_out();
        op_check("mul_after_div_entry", MDU_MUL, 1'b0, 1'b0, 32'd100, 32'd7, 32'h2BC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
